// File: rtl/l15_pkg.sv
// l15_pkg: constants and types shared by the L1.5 responder and the core
// frontend that talks to it.
//   - rqtype encodings (RQ_LOAD, RQ_IMISS, RQ_STORE)
//   - return-type encodings (LOAD_RET, IFILL_RET, ST_ACK, INT_RET, ERR_RET)
//   - responder state enum
//   - store_be(): byte enables within a 16-byte line for a sized store
package l15_pkg;

    localparam logic [4:0] RQ_LOAD  = 5'b00000;
    localparam logic [4:0] RQ_IMISS = 5'b10000;
    localparam logic [4:0] RQ_STORE = 5'b00001;

    localparam logic [3:0] LOAD_RET  = 4'b0000;
    localparam logic [3:0] IFILL_RET = 4'b0001;
    localparam logic [3:0] ST_ACK    = 4'b0100;
    localparam logic [3:0] INT_RET   = 4'b0111;
    localparam logic [3:0] ERR_RET   = 4'b1100;

    typedef enum logic [2:0] {
        ST_WAKE,
        ST_IDLE,
        ST_ACKW,
        ST_LAT,
        ST_RESP
    } l15_state_e;

    // Bit k of the result enables line byte k. Address bits below the
    // access size are dropped, so a misaligned store writes its aligned
    // container. Sizes above dword are treated as dword.
    function automatic logic [15:0] store_be(input logic [2:0] size,
                                             input logic [3:0] off);
        logic [7:0] be8;
        case (size)
            3'b000:  be8 = 8'b0000_0001 << off[2:0];
            3'b001:  be8 = 8'b0000_0011 << {off[2:1], 1'b0};
            3'b010:  be8 = 8'b0000_1111 << {off[2], 2'b00};
            default: be8 = 8'b1111_1111;
        endcase
        return off[3] ? {be8, 8'h00} : {8'h00, be8};
    endfunction

endpackage

// File: rtl/l15_line_ram.sv
// l15_line_ram: LINES x 128-bit line store.
//   clk              clock
//   rd_en/rd_addr    read request; rd_data updates on the next edge and is
//                    held until the next rd_en
//   wr_en/wr_addr/wr_be/wr_data
//                    byte-enable write; wr_be[k] selects line byte k, which
//                    lives in wr_data[127-8k -: 8] (byte 0 in the MSBs)
//   ld_en/ld_addr/ld_data
//                    full-line backdoor write; wins over a same-line write
//                    in the same cycle
module l15_line_ram #(
    parameter int LINES = 1024,
    parameter int AW    = $clog2(LINES)
) (
    input  logic          clk,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [127:0]  rd_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [15:0]   wr_be,
    input  logic [127:0]  wr_data,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [127:0]  ld_data
);

    logic [127:0] mem [LINES];
    logic [127:0] rd_data_reg;

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
        end
        if (wr_en) begin
            for (int b = 0; b < 16; b++) begin
                if (wr_be[b]) begin
                    mem[wr_addr][127-8*b -: 8] <= wr_data[127-8*b -: 8];
                end
            end
        end
        // Issued after the byte write so a same-line backdoor load overrides it.
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/l15_mem_responder.sv
// l15_mem_responder: stand-in L1.5 for the core's transducer interface.
// Presents INT_RET once after reset, then serves one request at a time from
// a line RAM: LOAD/IMISS return the line, STORE writes it, anything else or
// any out-of-window address returns ERR_RET.
//   clk, nrst                     clock, async active-low reset
//   transducer_l15_*              request from the core (val/rqtype/size/
//                                 address/data), req_ack consumes a response
//   l15_transducer_header_ack/ack request handshake
//   l15_transducer_val/returntype/data_0/data_1
//                                 response
//   ld_en/ld_line/ld_data         backdoor full-line RAM write
module l15_mem_responder
    import l15_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
    parameter int          MEM_LINES  = 1024,
    parameter int          LATENCY    = 2,
    parameter int          ACK_SPLIT  = 0,
    parameter int          WAKE_DELAY = 4,
    localparam int         LW         = $clog2(MEM_LINES)
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          transducer_l15_val,
    input  logic [4:0]    transducer_l15_rqtype,
    input  logic [2:0]    transducer_l15_size,
    input  logic [31:0]   transducer_l15_address,
    input  logic [63:0]   transducer_l15_data,
    output logic          l15_transducer_header_ack,
    output logic          l15_transducer_ack,
    output logic          l15_transducer_val,
    output logic [3:0]    l15_transducer_returntype,
    output logic [63:0]   l15_transducer_data_0,
    output logic [63:0]   l15_transducer_data_1,
    input  logic          transducer_l15_req_ack,
    input  logic          ld_en,
    input  logic [LW-1:0] ld_line,
    input  logic [127:0]  ld_data
);

    localparam int          WCW      = $clog2(WAKE_DELAY + 1) + 1;
    localparam int          LCW      = $clog2(LATENCY + 1) + 1;
    localparam int          LAT_LAST = (LATENCY > 1) ? LATENCY - 2 : 0;
    localparam logic [32:0] MEM_SPAN = 33'(MEM_LINES) * 33'd16;
    localparam l15_state_e  AFTER_ACK = (LATENCY > 1) ? ST_LAT : ST_RESP;

    l15_state_e     state_reg, state_next;
    logic [WCW-1:0] wake_cnt_reg, wake_cnt_next;
    logic [LCW-1:0] lat_cnt_reg, lat_cnt_next;
    // Only the decoded form of the request is kept; the raw fields are not
    // needed once line, return type and data/no-data are known.
    logic [LW-1:0]  line_reg;
    logic [3:0]     rtype_reg;
    logic           has_data_reg;

    logic [31:0]    offset;
    logic           in_range;
    logic [LW-1:0]  req_line;
    logic [3:0]     req_rtype;
    logic           req_has_data;
    logic           wake_done;
    logic           accept;
    logic [127:0]   ram_rd_data;

    // Request decode, modulo-2^32 offset so addresses below BASE wrap high.
    assign offset   = transducer_l15_address - BASE_ADDR;
    assign in_range = {1'b0, offset} < MEM_SPAN;
    assign req_line = offset[4 +: LW];

    always_comb begin
        req_rtype    = ERR_RET;
        req_has_data = 1'b0;
        if (in_range) begin
            case (transducer_l15_rqtype)
                RQ_LOAD:  begin req_rtype = LOAD_RET;  req_has_data = 1'b1; end
                RQ_IMISS: begin req_rtype = IFILL_RET; req_has_data = 1'b1; end
                RQ_STORE: req_rtype = ST_ACK;
                default:  req_rtype = ERR_RET;
            endcase
        end
    end

    assign wake_done = (wake_cnt_reg == WCW'(WAKE_DELAY));

    always_comb begin
        state_next                = state_reg;
        wake_cnt_next             = wake_cnt_reg;
        lat_cnt_next              = lat_cnt_reg;
        l15_transducer_header_ack = 1'b0;
        l15_transducer_val        = 1'b0;
        l15_transducer_returntype = 4'b0000;
        case (state_reg)
            ST_WAKE: begin
                if (!wake_done) begin
                    wake_cnt_next = wake_cnt_reg + 1'b1;
                end else begin
                    l15_transducer_val        = 1'b1;
                    l15_transducer_returntype = INT_RET;
                    if (transducer_l15_req_ack) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_IDLE: begin
                l15_transducer_header_ack = transducer_l15_val;
                if (transducer_l15_val) begin
                    lat_cnt_next = '0;
                    state_next   = (ACK_SPLIT != 0) ? ST_ACKW : AFTER_ACK;
                end
            end
            ST_ACKW: begin
                lat_cnt_next = '0;
                state_next   = AFTER_ACK;
            end
            ST_LAT: begin
                if (lat_cnt_reg == LCW'(LAT_LAST)) begin
                    state_next = ST_RESP;
                end else begin
                    lat_cnt_next = lat_cnt_reg + 1'b1;
                end
            end
            ST_RESP: begin
                l15_transducer_val        = 1'b1;
                l15_transducer_returntype = rtype_reg;
                if (transducer_l15_req_ack) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_WAKE;
        endcase
    end

    assign accept             = l15_transducer_header_ack;
    assign l15_transducer_ack = (ACK_SPLIT != 0) ? (state_reg == ST_ACKW) : accept;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg    <= ST_WAKE;
            wake_cnt_reg <= '0;
            lat_cnt_reg  <= '0;
            line_reg     <= '0;
            rtype_reg    <= 4'b0000;
            has_data_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wake_cnt_reg <= wake_cnt_next;
            lat_cnt_reg  <= lat_cnt_next;
            if (accept) begin
                line_reg     <= req_line;
                rtype_reg    <= req_rtype;
                has_data_reg <= req_has_data;
            end
        end
    end

    // The read fires on the edge that enters RESP, so the RAM output register
    // doubles as the response hold register. In IDLE the line comes straight
    // from the request, which covers LATENCY == 1 without ACK_SPLIT.
    l15_line_ram #(
        .LINES (MEM_LINES),
        .AW    (LW)
    ) u_ram (
        .clk     (clk),
        .rd_en   ((state_next == ST_RESP) && (state_reg != ST_RESP)),
        .rd_addr ((state_reg == ST_IDLE) ? req_line : line_reg),
        .rd_data (ram_rd_data),
        .wr_en   (accept && (transducer_l15_rqtype == RQ_STORE) && in_range),
        .wr_addr (req_line),
        .wr_be   (store_be(transducer_l15_size, offset[3:0])),
        .wr_data ({transducer_l15_data, transducer_l15_data}),
        .ld_en   (ld_en),
        .ld_addr (ld_line),
        .ld_data (ld_data)
    );

    // Data is forced to zero except for a data-carrying response, which also
    // hides the unreset RAM output register after reset.
    assign l15_transducer_data_0 = (state_reg == ST_RESP && has_data_reg) ? ram_rd_data[127:64] : 64'd0;
    assign l15_transducer_data_1 = (state_reg == ST_RESP && has_data_reg) ? ram_rd_data[63:0]   : 64'd0;

endmodule
